// File: rtl/regfile_param.sv
// regfile_param: parametrised general-purpose register file.
//   Storage has no bulk reset. After reset an init sequence clears one entry per
//   cycle so the array can map onto RAM. Two independent read ports, one write port.
// Ports:
//   clk        - system clock, all state changes on rising edge
//   reset      - synchronous, active-high; restarts the init sequence from entry 0
//   reg_write  - write enable
//   write_reg  - write address
//   write_data - write data
//   read_reg1  - read port 1 address
//   read_reg2  - read port 2 address
//   read_data1 - read port 1 data (combinational, or registered when READ_REG = 1)
//   read_data2 - read port 2 data (combinational, or registered when READ_REG = 1)
//   ready      - 1 once every entry has been cleared; writes are accepted only then
//   wr_drop    - one-cycle pulse after a write that arrived while ready = 0
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              ready,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_ptr, init_ptr_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_valid;
  logic [DATA_W-1:0] rv1, rv2;

  assign ready = (state == RUN);

  // Zero-register writes are discarded here so the bypass path never forwards them.
  assign wr_valid = reg_write && ready && !((ZERO_REG != 0) && (write_reg == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
      wr_drop  <= reg_write && !ready;
    end
  end

  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    case (state)
      INIT: begin
        if (init_ptr == LAST_ADDR) state_next = RUN;
        else init_ptr_next = init_ptr + 1'b1;
      end
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Single write port shared between the clearing sequence and normal writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) mem[init_ptr] <= '0;
      else if (wr_valid) mem[write_reg] <= write_data;
    end
  end

  always_comb begin
    rv1 = '0;
    if (ready && !((ZERO_REG != 0) && (read_reg1 == '0))) begin
      if ((BYPASS != 0) && wr_valid && (write_reg == read_reg1)) rv1 = write_data;
      else rv1 = mem[read_reg1];
    end
  end

  always_comb begin
    rv2 = '0;
    if (ready && !((ZERO_REG != 0) && (read_reg2 == '0))) begin
      if ((BYPASS != 0) && wr_valid && (write_reg == read_reg2)) rv2 = write_data;
      else rv2 = mem[read_reg2];
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          read_data1 <= '0;
          read_data2 <= '0;
        end else begin
          read_data1 <= rv1;
          read_data2 <= rv2;
        end
      end
    end else begin : g_rd_comb
      assign read_data1 = rv1;
      assign read_data2 = rv2;
    end
  endgenerate

endmodule
